// File: rtl/uart_line_monitor.sv
// UART receive monitor: oversampled frame receiver feeding a bounded line
// assembler, with completed lines presented through a valid/ready holding register.
module uart_line_monitor #(
  parameter int          CLK_HZ       = 50_000_000,
  parameter int          BIT_RATE     = 9600,
  parameter int          PAYLOAD_BITS = 8,
  parameter int          PARITY       = 0,
  parameter int          STOP_BITS    = 1,
  parameter int          LINE_MAX     = 132,
  parameter logic [7:0]  TERMINATOR   = 8'h0a
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              uart_rxd,
  input  logic                              uart_rx_en,
  output logic                              char_valid,
  output logic [7:0]                        char_data,
  output logic                              char_err,
  output logic                              break_det,
  output logic                              line_valid,
  input  logic                              line_ready,
  output logic [LINE_MAX*8-1:0]             line_data,
  output logic [$clog2(LINE_MAX+1)-1:0]     line_len,
  output logic                              line_overflow,
  output logic                              line_err,
  output logic                              line_dropped
);
  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int CW  = $clog2(CPB + 1);
  localparam int LW  = $clog2(LINE_MAX + 1);
  localparam int LD  = LINE_MAX * 8;
  localparam logic [CW-1:0] HALF      = CW'(CPB / 2);
  localparam logic [CW-1:0] FULL      = CW'(CPB - 1);
  localparam logic [2:0]    LAST_DATA = 3'(PAYLOAD_BITS - 1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic [LW-1:0] LMAX      = LW'(LINE_MAX);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRKWAIT} state_t;

  state_t        state, state_n;
  logic [1:0]    sync;
  logic          rxd_s, rxd_q;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shreg, sh_n;
  logic          par_err, pe_n, stop_low, sl_n;
  logic          cv_n, ce_n, bk_n, tick, low;

  assign rxd_s = sync[1];
  assign tick  = (cnt == '0);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    sh_n    = shreg;
    pe_n    = par_err;
    sl_n    = stop_low;
    cv_n    = 1'b0;
    ce_n    = 1'b0;
    bk_n    = 1'b0;
    low     = stop_low | ~rxd_s;
    case (state)
      S_IDLE:
        if (uart_rx_en && rxd_q && !rxd_s) begin
          state_n = S_START;
          cnt_n   = HALF;
        end
      S_START:
        if (!tick) cnt_n = cnt - CW'(1);
        else if (rxd_s) state_n = S_IDLE;   // start bit did not survive to mid-bit
        else begin
          state_n = S_DATA;
          cnt_n   = FULL;
          bit_n   = '0;
          sh_n    = '0;
          pe_n    = 1'b0;
          sl_n    = 1'b0;
        end
      S_DATA:
        if (!tick) cnt_n = cnt - CW'(1);
        else begin
          sh_n[bit_idx] = rxd_s;
          cnt_n         = FULL;
          if (bit_idx == LAST_DATA) begin
            bit_n   = '0;
            state_n = (PARITY != 0) ? S_PARITY : S_STOP;
          end else bit_n = bit_idx + 3'd1;
        end
      S_PARITY:
        if (!tick) cnt_n = cnt - CW'(1);
        else begin
          pe_n    = ((^shreg) ^ rxd_s) != (PARITY == 1);
          cnt_n   = FULL;
          bit_n   = '0;
          state_n = S_STOP;
        end
      S_STOP:
        if (!tick) cnt_n = cnt - CW'(1);
        else begin
          cnt_n = FULL;
          if (bit_idx == LAST_STOP) begin
            state_n = S_IDLE;
            if (low && shreg == '0 && !par_err) begin
              bk_n    = 1'b1;
              state_n = S_BRKWAIT;
            end else if (low || par_err) ce_n = 1'b1;
            else cv_n = 1'b1;
          end else begin
            sl_n  = low;
            bit_n = bit_idx + 3'd1;
          end
        end
      S_BRKWAIT:
        if (rxd_s) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (!uart_rx_en) begin
      state_n = S_IDLE;
      cv_n    = 1'b0;
      ce_n    = 1'b0;
      bk_n    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync       <= 2'b11;
      rxd_q      <= 1'b1;
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_err    <= 1'b0;
      stop_low   <= 1'b0;
      char_valid <= 1'b0;
      char_err   <= 1'b0;
      break_det  <= 1'b0;
      char_data  <= '0;
    end else begin
      sync       <= {sync[0], uart_rxd};
      rxd_q      <= rxd_s;
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      shreg      <= sh_n;
      par_err    <= pe_n;
      stop_low   <= sl_n;
      char_valid <= cv_n;
      char_err   <= ce_n;
      break_det  <= bk_n;
      if (cv_n) char_data <= shreg;
    end
  end

  // Line assembler and holding register
  logic [LD-1:0] a_data;
  logic [LW-1:0] a_len;
  logic          a_ovf, a_err, accept, complete;

  assign complete = char_valid && (char_data == TERMINATOR);
  assign accept   = !line_valid || line_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_data        <= '0;
      a_len         <= '0;
      a_ovf         <= 1'b0;
      a_err         <= 1'b0;
      line_valid    <= 1'b0;
      line_data     <= '0;
      line_len      <= '0;
      line_overflow <= 1'b0;
      line_err      <= 1'b0;
      line_dropped  <= 1'b0;
    end else begin
      line_dropped <= 1'b0;
      if (line_valid && line_ready) line_valid <= 1'b0;
      if (char_err) a_err <= 1'b1;
      if (complete) begin
        if (accept) begin
          line_valid    <= 1'b1;
          line_data     <= a_data;
          line_len      <= a_len;
          line_overflow <= a_ovf;
          line_err      <= a_err;
        end else line_dropped <= 1'b1;
        a_data <= '0;
        a_len  <= '0;
        a_ovf  <= 1'b0;
        a_err  <= 1'b0;
      end else if (char_valid) begin
        if (a_len < LMAX) begin
          a_data <= (a_data << 8) | LD'(char_data);
          a_len  <= a_len + LW'(1);
        end else a_ovf <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_line_monitor.sv
// Randomised scoreboard bench: frames are driven bit by bit, a queue-based line
// model predicts character events and delivered lines.
module tb_uart_line_monitor;
  localparam int         CPB  = 10;
  localparam int         LM   = 4;
  localparam int         LW   = $clog2(LM + 1);
  localparam logic [7:0] TERM = 8'h0a;

  logic            clk = 1'b0, rst = 1'b1, rxd = 1'b1, rx_en = 1'b0, ready = 1'b1;
  logic            char_valid, char_err, break_det, line_valid, line_overflow, line_err, line_dropped;
  logic [7:0]      char_data;
  logic [LM*8-1:0] line_data;
  logic [LW-1:0]   line_len;

  uart_line_monitor #(.CLK_HZ(50_000_000), .BIT_RATE(5_000_000), .PAYLOAD_BITS(8), .PARITY(2),
                      .STOP_BITS(1), .LINE_MAX(LM), .TERMINATOR(TERM)) dut (
    .clk(clk), .reset(rst), .uart_rxd(rxd), .uart_rx_en(rx_en),
    .char_valid(char_valid), .char_data(char_data), .char_err(char_err), .break_det(break_det),
    .line_valid(line_valid), .line_ready(ready), .line_data(line_data), .line_len(line_len),
    .line_overflow(line_overflow), .line_err(line_err), .line_dropped(line_dropped));

  always #5 clk = ~clk;

  typedef struct { int kind; logic [7:0] data; } ev_t;        // 0 valid, 1 err, 2 break
  typedef struct { logic [LM*8-1:0] data; int len; bit ovf; bit err; } ln_t;

  ev_t  evq[$];
  ln_t  lnq[$];
  int   checks = 0, errors = 0, drops_seen = 0, drops_exp = 0;
  byte  cur[$];
  bit   cur_ovf = 0, cur_err = 0, hold_mode = 0, held = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---- reference model ----
  function automatic void model_reset();
    cur.delete(); cur_ovf = 0; cur_err = 0;
  endfunction

  function automatic void finish_line();
    ln_t l;
    l.data = '0; l.len = cur.size(); l.ovf = cur_ovf; l.err = cur_err;
    foreach (cur[i]) l.data = (l.data << 8) | (LM*8)'(cur[i]);
    if (!hold_mode || !held) begin
      lnq.push_back(l);
      if (hold_mode) held = 1;
    end else drops_exp++;
    model_reset();
  endfunction

  function automatic int classify(logic [7:0] d, bit par_bad, bit stop_low);
    if (stop_low && d == 8'h00 && !par_bad) return 2;
    if (stop_low || par_bad) return 1;
    return 0;
  endfunction

  function automatic void model_char(int kind, logic [7:0] ch);
    if (kind == 1) cur_err = 1;
    if (kind == 0) begin
      if (ch == TERM) finish_line();
      else if (cur.size() < LM) cur.push_back(ch);
      else cur_ovf = 1;
    end
  endfunction

  // ---- stimulus helpers ----
  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] ch, input bit par_bad = 0, input bit stop_low = 0);
    ev_t e;
    e.kind = classify(ch, par_bad, stop_low); e.data = ch;
    evq.push_back(e);
    model_char(e.kind, ch);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(ch[i]);
    drive_bit((^ch) ^ par_bad);
    drive_bit(!stop_low);
    drive_bit(1'b1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_frame(s[i]);
  endtask

  task automatic drain();
    int t = 0;
    while ((evq.size() != 0 || lnq.size() != 0) && t < 3000) begin
      @(negedge clk); t++;
    end
    chk("drain_pending", evq.size() + lnq.size(), 0);
  endtask

  task automatic check_quiet(input string nm);
    chk({nm, "_outs"}, {char_valid, char_err, break_det, line_valid, line_dropped,
                        line_overflow, line_err, char_data, line_len}, '0);
    chk({nm, "_ldata"}, line_data, '0);
  endtask

  // ---- monitors ----
  always @(negedge clk) if (!rst) begin
    if (char_valid || char_err || break_det) begin
      int kind;
      ev_t e;
      kind = char_valid ? 0 : (char_err ? 1 : 2);
      chk("char_onehot", char_valid + char_err + break_det, 1);
      if (evq.size() == 0) begin
        checks++; errors++;
        $display("FAIL char_unexpected: got kind %0d data %0h expected none", kind, char_data);
      end else begin
        e = evq.pop_front();
        chk("char_kind", kind, e.kind);
        if (kind == 0) chk("char_data", char_data, e.data);
      end
    end
    if (line_valid && ready) begin
      ln_t l;
      if (lnq.size() == 0) begin
        checks++; errors++;
        $display("FAIL line_unexpected: got len %0d data %0h expected none", line_len, line_data);
      end else begin
        l = lnq.pop_front();
        chk("line_len", line_len, l.len);
        chk("line_data", line_data, l.data);
        chk("line_overflow", line_overflow, l.ovf);
        chk("line_err", line_err, l.err);
      end
    end
    if (line_dropped) drops_seen++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  // ---- main sequence ----
  initial begin
    repeat (3) @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    rst = 0; rx_en = 1;
    repeat (5) drive_bit(1'b1);

    send_str("Hi\n");
    send_frame(8'h41, 1); send_str("B\n");        // parity error then good line
    send_str("ABCDEF\n");                          // overflow
    send_frame(8'h43, 0, 1); send_str("D\n");     // framing error
    drain();

    // holding register full: second line is dropped
    hold_mode = 1; held = 0; ready = 0;
    send_str("a\nb\n");
    repeat (3) drive_bit(1'b1);
    chk("hold_valid", line_valid, 1);
    chk("hold_len", line_len, 1);
    chk("hold_data", line_data, 32'h61);
    chk("drops_after_hold", drops_seen, 1);
    @(posedge clk); #1; ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("valid_drop_after_hs", line_valid, 0);
    hold_mode = 0;
    drain();

    // break: 20 bit times low, then a clean frame
    begin
      ev_t e; e.kind = 2; e.data = 8'h00; evq.push_back(e);
    end
    rxd = 0; repeat (20 * CPB) @(posedge clk); #1;
    repeat (3) drive_bit(1'b1);
    send_frame(8'h55);
    drain();

    // 3-cycle glitch: nothing expected
    rxd = 0; repeat (3) @(posedge clk); #1;
    repeat (3) drive_bit(1'b1);

    // receive disabled mid-frame
    drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
    rx_en = 0;
    for (int i = 0; i < 7; i++) drive_bit(i[0]);
    drive_bit(1'b1); rx_en = 1;
    repeat (2) drive_bit(1'b1);
    send_str("x\n");
    drain();

    // reset mid-line and mid-frame
    send_str("AB");
    drain();
    drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
    rst = 1; rxd = 1; model_reset();
    repeat (2) @(negedge clk);
    check_quiet("midreset");
    @(posedge clk); #1; rst = 0;
    repeat (3) drive_bit(1'b1);
    send_str("C\n");
    drain();

    // random traffic with parity/framing errors
    for (int n = 0; n < 60; n++) begin
      logic [7:0] ch;
      int r, e;
      r  = $urandom_range(0, 5);
      ch = (r == 0) ? TERM : 8'($urandom_range(32, 126));
      e  = $urandom_range(0, 9);
      send_frame(ch, e == 0, e == 1);
    end
    send_frame(TERM);
    drain();

    chk("drops_total", drops_seen, drops_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_line_monitor.md
# uart_line_monitor

Parametrised UART receive monitor for the co-simulation testbench. It integrates bit-level reception (configurable payload, parity and stop bits, break and glitch detection) with a bounded line assembler. Completed lines are delivered through a valid/ready holding register, so bench components can consume whole text lines, error flags and lengths rather than individual bytes. It sits on a DUT UART TX pin alongside the existing console loggers.

## Interface
- CLK_HZ, 50_000_000: clock frequency.
- BIT_RATE, 9600: baud; CPB = CLK_HZ/BIT_RATE (integer divide, CPB ≥ 4 required).
- PAYLOAD_BITS, 8: data bits, 5–8.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.
- LINE_MAX, 132: max stored characters per line.
- TERMINATOR, 8'h0a: end-of-line character.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- uart_rxd  in  1  serial input, asynchronous, idle high.
- uart_rx_en  in  1  receive enable.
- char_valid  out  1  one-cycle pulse, character received without error.
- char_data  out  8  received character, zero-extended above PAYLOAD_BITS.
- char_err  out  1  one-cycle pulse, parity or framing error.
- break_det  out  1  one-cycle pulse per break condition.
- line_valid  out  1  holding register holds a line.
- line_ready  in  1  consumer accepts the line.
- line_data  out  LINE_MAX*8  line text; last character in bits [7:0], earlier characters above, unused upper bytes zero.
- line_len  out  $clog2(LINE_MAX+1)  stored characters.
- line_overflow  out  1  characters were discarded from this line.
- line_err  out  1  at least one errored character occurred in this line.
- line_dropped  out  1  one-cycle pulse, completed line lost because the holding register was full.

## Operation
- uart_rxd passes through a 2-flop synchronizer (reset value 1). All sampling uses the synchronized value.
- Receive FSM states: IDLE, START, DATA, PARITY, STOP, BRKWAIT.
- IDLE: on a synchronized falling level with uart_rx_en=1, go to START and load the counter with CPB/2.
- START: at mid-bit, if the line is high (glitch), return to IDLE with no output. Otherwise go to DATA.
- DATA: sample every CPB cycles, LSB first, PAYLOAD_BITS samples. Then go to PARITY if PARITY≠0, else STOP.
- PARITY: sample one bit. A mismatch against the odd/even rule sets a pending parity error.
- STOP: sample STOP_BITS bits.
  - Any low stop sample with all data bits 0 and no parity error: break. Pulse break_det and go to BRKWAIT. No char_valid, no char_err.
  - Other low stop sample: framing error. Pulse char_err and return to IDLE after the last stop sample.
  - Parity error with a good stop: pulse char_err.
  - Otherwise: pulse char_valid.
- BRKWAIT: wait for the synchronized line to be high, then go to IDLE.
- uart_rx_en=0 in any state forces IDLE at the next edge. A partial frame is discarded silently.
- Line assembler, on each char_valid:
  - Character == TERMINATOR: complete the line (terminator not stored).
  - Else, if len < LINE_MAX: shift the character into [7:0] and increment len.
  - Else: discard the character and set the line's overflow flag.
- Each char_err sets the line's err flag; the errored character is never stored.
- Line completion:
  - Holding register empty, or line_valid && line_ready this cycle: copy data/len/flags into it and clear the assembly buffer.
  - Otherwise: pulse line_dropped and clear the assembly buffer.
- A zero-length line (bare terminator) is delivered with line_len=0.
- Holding register: line_valid stays high and its outputs stay stable until line_ready is sampled high.

## Timing
- Reset values: all outputs 0 except char_data=0 and line_data=0. FSM is in IDLE, synchronizer is 1, buffers are empty.
- Start edge to START entry: 2–3 cycles of synchronizer latency.
- char_valid / char_err / break_det assert the cycle after the final stop-bit sample.
- line_valid asserts the cycle after the terminator's char_valid.
- line_valid deasserts the cycle after the line_valid && line_ready handshake, unless it is reloaded in that same cycle.
- A simultaneous completion and handshake loads the new line with no bubble. line_valid stays high.
- Reset mid-frame or mid-line: immediate clear; no output pulses are generated.

## Test plan
- CLK_HZ=50e6, BIT_RATE=5e6 (CPB=10), 8N1; send "Hi\n" → two char_valid (0x48, 0x69), then line_valid with line_len=2, line_data[15:0]=0x4869, both flags 0.
- PARITY=2; send 0x41 with an odd parity bit, then "B\n" → char_err pulse; line delivered with len=1, data[7:0]=0x42, line_err=1.
- LINE_MAX=4; send "ABCDEF\n" → line_len=4, line_data=0x41424344, line_overflow=1.
- Hold line_ready=0 and send "a\n" then "b\n" → first line held, line_dropped pulses once on the second terminator. Raising line_ready then yields the "a" line and line_valid drops the next cycle.
- Drive uart_rxd low for 20 bit times → exactly one break_det, no char_valid or char_err. Next frame 0x55 is received correctly.
- Low glitch of 3 cycles; separately, deassert uart_rx_en mid-frame, then reset mid-frame → no outputs, and a subsequent clean frame is received correctly.
